can_rx: RTL and testbench

//  Bit-level receiver for the team's CAN-based link-layer frame; counterpart of the frame transmitter.

---
 rtl/can_rx.sv | 236 +++++++++++++++++++++++
 tb/tb_can_rx.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/can_rx.sv
// Bit-level receiver for the link-layer CAN frame: destuffs, checks CRC/form,
// unpacks the header and data fields and drives the ACK slot on a good frame.
module can_rx #(
  parameter int ACK_EN    = 1,
  parameter int IDLE_BITS = 11
) (
  input  logic        clk_can_i,
  input  logic        rst_i,
  input  logic        rx_i,
  output logic        tx_o,
  output logic        rx_busy_o,
  output logic        rx_valid_o,
  output logic        rx_error_o,
  output logic [1:0]  rx_error_code_o,
  output logic        message_type_o,
  output logic [5:0]  local_address_o,
  output logic [5:0]  remote_address_o,
  output logic [1:0]  handshake_o,
  output logic [1:0]  atribute_o,
  output logic [3:0]  expand_count_o,
  output logic [7:0]  cmd_data_sign_o,
  output logic [3:0]  dlc_o,
  output logic [63:0] rx_data_o
);

  localparam logic [2:0] ST_INTEGRATE = 3'd0;
  localparam logic [2:0] ST_IDLE      = 3'd1;
  localparam logic [2:0] ST_FIELDS    = 3'd2;
  localparam logic [2:0] ST_CRC_DEL   = 3'd3;
  localparam logic [2:0] ST_ACK       = 3'd4;
  localparam logic [2:0] ST_ACK_DEL   = 3'd5;
  localparam logic [2:0] ST_EOF       = 3'd6;

  localparam logic [1:0] ERR_STUFF = 2'd1;
  localparam logic [1:0] ERR_FORM  = 2'd2;
  localparam logic [1:0] ERR_CRC   = 2'd3;

  localparam int unsigned IW = $clog2(IDLE_BITS + 1);
  localparam logic [IW-1:0] IDLE_LAST = IW'(IDLE_BITS - 1);

  // Destuffed bit index counts from message_type (0) to the last CRC bit (116).
  localparam logic [6:0] SRR_IDX       = 7'd11;
  localparam logic [6:0] IDE_IDX       = 7'd12;
  localparam logic [6:0] RTR_IDX       = 7'd31;
  localparam logic [6:0] RES0_IDX      = 7'd32;
  localparam logic [6:0] RES1_IDX      = 7'd33;
  localparam logic [6:0] CRC_START_IDX = 7'd102;
  localparam logic [6:0] LAST_CRC_IDX  = 7'd116;
  localparam logic [6:0] DONE_IDX      = 7'd117;

  logic [2:0]    state;
  logic [IW-1:0] integ_cnt;
  logic [6:0]    bit_idx;
  logic [2:0]    run_cnt;
  logic          prev_bit;
  logic [14:0]   crc_calc;
  logic [14:0]   crc_rx;
  logic [96:0]   sreg;
  logic [2:0]    eof_cnt;

  logic          stuff_slot;
  logic [2:0]    run_next;
  logic          form_bit;
  logic          keep_bit;
  logic          crc_fb;
  logic [14:0]   crc_next;
  logic          err_det;
  logic [1:0]    err_kind;
  logic          frame_done;

  always_comb begin
    stuff_slot = (run_cnt == 3'd5);
    run_next   = (rx_i == prev_bit) ? run_cnt + 3'd1 : 3'd1;
    form_bit   = (bit_idx == SRR_IDX) || (bit_idx == IDE_IDX);
    keep_bit   = (bit_idx < CRC_START_IDX) && !form_bit &&
                 (bit_idx != RTR_IDX) && (bit_idx != RES0_IDX) && (bit_idx != RES1_IDX);
    crc_fb     = rx_i ^ crc_calc[14];
    crc_next   = {crc_calc[13:0], 1'b0} ^ (crc_fb ? 15'h4599 : 15'h0000);
    frame_done = (state == ST_EOF) && rx_i && (eof_cnt == 3'd6);
  end

  always_comb begin
    err_det  = 1'b0;
    err_kind = 2'd0;
    case (state)
      ST_FIELDS: begin
        if (stuff_slot) begin
          if (rx_i == prev_bit) begin
            err_det  = 1'b1;
            err_kind = ERR_STUFF;
          end
        end else if (form_bit && !rx_i) begin
          err_det  = 1'b1;
          err_kind = ERR_FORM;
        end
      end
      ST_CRC_DEL: begin
        if (crc_calc != crc_rx) begin
          err_det  = 1'b1;
          err_kind = ERR_CRC;
        end else if (!rx_i) begin
          err_det  = 1'b1;
          err_kind = ERR_FORM;
        end
      end
      ST_ACK_DEL, ST_EOF: begin
        if (!rx_i) begin
          err_det  = 1'b1;
          err_kind = ERR_FORM;
        end
      end
      default: begin
        err_det  = 1'b0;
        err_kind = 2'd0;
      end
    endcase
  end

  always_ff @(posedge clk_can_i or negedge rst_i) begin
    if (!rst_i) begin
      state     <= ST_INTEGRATE;
      integ_cnt <= '0;
      bit_idx   <= '0;
      run_cnt   <= '0;
      prev_bit  <= 1'b0;
      crc_calc  <= '0;
      crc_rx    <= '0;
      sreg      <= '0;
      eof_cnt   <= '0;
    end else if (err_det) begin
      state     <= ST_INTEGRATE;
      integ_cnt <= '0;
    end else begin
      case (state)
        ST_INTEGRATE: begin
          if (rx_i) begin
            if (integ_cnt == IDLE_LAST) begin
              state     <= ST_IDLE;
              integ_cnt <= '0;
            end else begin
              integ_cnt <= integ_cnt + IW'(1);
            end
          end else begin
            integ_cnt <= '0;
          end
        end
        ST_IDLE: begin
          if (!rx_i) begin
            state    <= ST_FIELDS;
            bit_idx  <= '0;
            run_cnt  <= 3'd1;
            prev_bit <= 1'b0;
            crc_calc <= '0;
          end
        end
        ST_FIELDS: begin
          prev_bit <= rx_i;
          if (stuff_slot) begin
            run_cnt <= 3'd1;
            if (bit_idx == DONE_IDX) state <= ST_CRC_DEL;
          end else begin
            run_cnt <= run_next;
            bit_idx <= bit_idx + 7'd1;
            if (keep_bit) sreg <= {sreg[95:0], rx_i};
            if (bit_idx < CRC_START_IDX) crc_calc <= crc_next;
            else                         crc_rx   <= {crc_rx[13:0], rx_i};
            // A run of five ending on the last CRC bit still owes a stuff bit
            // before the delimiter, so stay in FIELDS with the index parked at DONE.
            if (bit_idx == LAST_CRC_IDX && run_next != 3'd5) state <= ST_CRC_DEL;
          end
        end
        ST_CRC_DEL: state <= ST_ACK;
        ST_ACK:     state <= ST_ACK_DEL;
        ST_ACK_DEL: begin
          state   <= ST_EOF;
          eof_cnt <= '0;
        end
        ST_EOF: begin
          if (eof_cnt == 3'd6) state <= ST_IDLE;
          else                 eof_cnt <= eof_cnt + 3'd1;
        end
        default: state <= ST_INTEGRATE;
      endcase
    end
  end

  always_ff @(posedge clk_can_i or negedge rst_i) begin
    if (!rst_i) begin
      rx_valid_o      <= 1'b0;
      rx_error_o      <= 1'b0;
      rx_error_code_o <= '0;
    end else begin
      rx_valid_o <= frame_done;
      rx_error_o <= err_det;
      if (err_det) rx_error_code_o <= err_kind;
    end
  end

  // ACK is registered at the delimiter edge so it covers exactly the ACK slot.
  always_ff @(posedge clk_can_i or negedge rst_i) begin
    if (!rst_i) begin
      tx_o <= 1'b1;
    end else if (state == ST_CRC_DEL && !err_det && ACK_EN != 0) begin
      tx_o <= 1'b0;
    end else begin
      tx_o <= 1'b1;
    end
  end

  always_ff @(posedge clk_can_i or negedge rst_i) begin
    if (!rst_i) begin
      message_type_o   <= 1'b0;
      local_address_o  <= '0;
      remote_address_o <= '0;
      handshake_o      <= '0;
      atribute_o       <= '0;
      expand_count_o   <= '0;
      cmd_data_sign_o  <= '0;
      dlc_o            <= '0;
      rx_data_o        <= '0;
    end else if (frame_done) begin
      message_type_o   <= sreg[96];
      local_address_o  <= sreg[95:90];
      remote_address_o <= sreg[89:84];
      handshake_o      <= sreg[83:82];
      atribute_o       <= sreg[81:80];
      expand_count_o   <= sreg[79:76];
      cmd_data_sign_o  <= sreg[75:68];
      dlc_o            <= sreg[67:64];
      rx_data_o        <= sreg[63:0];
    end
  end

  assign rx_busy_o = (state != ST_INTEGRATE) && (state != ST_IDLE);

endmodule

// File: tb/tb_can_rx.sv
// Directed bench for can_rx: builds stuffed frames from field values and
// checks decode, error codes, ACK timing, busy length and reset abort.
module tb_can_rx;

  logic        clk_can_i = 1'b0;
  logic        rst_i     = 1'b1;
  logic        rx_i      = 1'b1;
  logic        tx_o;
  logic        rx_busy_o;
  logic        rx_valid_o;
  logic        rx_error_o;
  logic [1:0]  rx_error_code_o;
  logic        message_type_o;
  logic [5:0]  local_address_o;
  logic [5:0]  remote_address_o;
  logic [1:0]  handshake_o;
  logic [1:0]  atribute_o;
  logic [3:0]  expand_count_o;
  logic [7:0]  cmd_data_sign_o;
  logic [3:0]  dlc_o;
  logic [63:0] rx_data_o;

  always #5 clk_can_i = ~clk_can_i;

  can_rx #(.ACK_EN(1), .IDLE_BITS(11)) dut (
    .clk_can_i        (clk_can_i),
    .rst_i            (rst_i),
    .rx_i             (rx_i),
    .tx_o             (tx_o),
    .rx_busy_o        (rx_busy_o),
    .rx_valid_o       (rx_valid_o),
    .rx_error_o       (rx_error_o),
    .rx_error_code_o  (rx_error_code_o),
    .message_type_o   (message_type_o),
    .local_address_o  (local_address_o),
    .remote_address_o (remote_address_o),
    .handshake_o      (handshake_o),
    .atribute_o       (atribute_o),
    .expand_count_o   (expand_count_o),
    .cmd_data_sign_o  (cmd_data_sign_o),
    .dlc_o            (dlc_o),
    .rx_data_o        (rx_data_o)
  );

  // Field vector order: type, local, remote, hs, attr, exp, cmd, dlc, data.
  localparam logic [96:0] F1 = {1'b1, 6'h15, 6'h2A, 2'b01, 2'b10, 4'h3, 8'hA5, 4'h8,
                                64'h0123_4567_89AB_CDEF};
  localparam logic [96:0] F2 = {1'b1, 6'h15, 6'h2A, 2'b01, 2'b10, 4'h3, 8'hFF, 4'h8,
                                64'h0};

  logic [96:0] obs_f;
  assign obs_f = {message_type_o, local_address_o, remote_address_o, handshake_o,
                  atribute_o, expand_count_o, cmd_data_sign_o, dlc_o, rx_data_o};

  int vectors     = 0;
  int miscompares = 0;

  bit uq[$];
  bit sq[$];
  int map_q[$];
  int body_len;
  int stuff_cnt;

  int          valid_cnt, valid_at, err_cnt, err_at, low_cnt, low_at, busy_cnt, stray_cnt;
  logic [1:0]  err_code_seen;
  logic [96:0] last_f, first_valid_f;

  task automatic clear_mon();
    valid_cnt = 0; valid_at = -2; err_cnt = 0; err_at = -2;
    low_cnt = 0; low_at = -2; busy_cnt = 0; stray_cnt = 0;
    err_code_seen = 2'd0; last_f = obs_f; first_valid_f = '0;
  endtask

  task automatic drive_bit(input logic b, input int idx);
    rx_i = b;
    @(posedge clk_can_i);
    #1;
    if (rx_valid_o) begin
      if (valid_cnt == 0) first_valid_f = obs_f;
      valid_cnt++;
      valid_at = idx;
    end
    if (rx_error_o) begin
      err_cnt++;
      err_at = idx;
      err_code_seen = rx_error_code_o;
    end
    if (!tx_o) begin
      low_cnt++;
      low_at = idx;
    end
    if (rx_busy_o) busy_cnt++;
    if (obs_f !== last_f && !rx_valid_o) stray_cnt++;
    last_f = obs_f;
  endtask

  task automatic idle_bits(input int n);
    for (int i = 0; i < n; i++) drive_bit(1'b1, -1);
  endtask

  task automatic push_bits(input logic [63:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) uq.push_back(v[i]);
  endtask

  task automatic build_frame(input logic [96:0] f, input logic ide);
    logic [14:0] crc;
    logic        fb;
    uq.delete();
    push_bits(64'd0, 1);
    push_bits(64'(f[96]), 1);
    push_bits(64'(f[95:90]), 6);
    push_bits(64'(f[89:86]), 4);
    push_bits(64'd1, 1);
    push_bits(64'(ide), 1);
    push_bits(64'(f[85:84]), 2);
    push_bits(64'(f[83:82]), 2);
    push_bits(64'(f[81:80]), 2);
    push_bits(64'(f[79:76]), 4);
    push_bits(64'(f[75:68]), 8);
    push_bits(64'd0, 1);
    push_bits(64'd0, 2);
    push_bits(64'(f[67:64]), 4);
    push_bits(f[63:0], 64);
    crc = '0;
    for (int i = 1; i < uq.size(); i++) begin
      fb  = uq[i] ^ crc[14];
      crc = {crc[13:0], 1'b0};
      if (fb) crc = crc ^ 15'h4599;
    end
    push_bits(64'(crc), 15);
  endtask

  task automatic stuff_frame();
    bit prev;
    int run;
    sq.delete(); map_q.delete();
    stuff_cnt = 0; run = 0; prev = 1'b0;
    for (int i = 0; i < uq.size(); i++) begin
      sq.push_back(uq[i]);
      map_q.push_back(sq.size() - 1);
      if (i == 0 || uq[i] != prev) run = 1;
      else run++;
      prev = uq[i];
      if (run == 5) begin
        sq.push_back(!prev);
        prev = !prev;
        run = 1;
        stuff_cnt++;
      end
    end
    body_len = sq.size();
    sq.push_back(1'b1);
    sq.push_back(1'b0);
    for (int i = 0; i < 8; i++) sq.push_back(1'b1);
  endtask

  task automatic send_range(input int from, input int to_excl);
    for (int i = from; i < to_excl; i++) drive_bit(sq[i], i);
  endtask

  task automatic test_reset();
    #2 rst_i = 1'b0;
    repeat (3) @(posedge clk_can_i);
    #1;
    vectors++; if (tx_o !== 1'b1) begin miscompares++; $display("FAIL reset_tx: got %b want 1", tx_o); end
    vectors++; if (rx_busy_o !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b want 0", rx_busy_o); end
    vectors++; if (rx_valid_o !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %b want 0", rx_valid_o); end
    vectors++; if (rx_error_o !== 1'b0) begin miscompares++; $display("FAIL reset_err: got %b want 0", rx_error_o); end
    vectors++; if (rx_error_code_o !== 2'd0) begin miscompares++; $display("FAIL reset_code: got %0d want 0", rx_error_code_o); end
    vectors++; if (obs_f !== '0) begin miscompares++; $display("FAIL reset_fields: got %h want 0", obs_f); end
    rst_i = 1'b1;
  endtask

  task automatic test_nominal();
    idle_bits(12);
    build_frame(F1, 1'b1);
    stuff_frame();
    clear_mon();
    send_range(0, sq.size());
    idle_bits(2);
    vectors++; if (obs_f !== F1) begin miscompares++; $display("FAIL nom_fields: got %h want %h", obs_f, F1); end
    vectors++; if (valid_cnt != 1) begin miscompares++; $display("FAIL nom_valid_cnt: got %0d want 1", valid_cnt); end
    vectors++; if (valid_at != sq.size() - 1) begin miscompares++; $display("FAIL nom_valid_at: got %0d want %0d", valid_at, sq.size() - 1); end
    vectors++; if (err_cnt != 0) begin miscompares++; $display("FAIL nom_err: got %0d want 0", err_cnt); end
    vectors++; if (low_cnt != 1) begin miscompares++; $display("FAIL nom_ack_cnt: got %0d want 1", low_cnt); end
    vectors++; if (low_at != body_len) begin miscompares++; $display("FAIL nom_ack_at: got %0d want %0d", low_at, body_len); end
    vectors++; if (busy_cnt != sq.size() - 1) begin miscompares++; $display("FAIL nom_busy: got %0d want %0d", busy_cnt, sq.size() - 1); end
    vectors++; if (stray_cnt != 0) begin miscompares++; $display("FAIL nom_field_hold: got %0d want 0", stray_cnt); end
  endtask

  task automatic test_dense_stuffing();
    idle_bits(12);
    build_frame(F2, 1'b1);
    stuff_frame();
    clear_mon();
    send_range(0, sq.size());
    idle_bits(2);
    vectors++; if (obs_f !== F2) begin miscompares++; $display("FAIL dense_fields: got %h want %h", obs_f, F2); end
    vectors++; if (valid_cnt != 1) begin miscompares++; $display("FAIL dense_valid: got %0d want 1", valid_cnt); end
    vectors++; if (err_cnt != 0) begin miscompares++; $display("FAIL dense_err: got %0d want 0", err_cnt); end
    // 118 unstuffed bits SOF..CRC plus 10 tail bits; busy starts after the SOF sample.
    vectors++; if (busy_cnt != 118 + stuff_cnt + 9) begin miscompares++; $display("FAIL dense_busy: got %0d want %0d", busy_cnt, 118 + stuff_cnt + 9); end
  endtask

  task automatic test_crc_error();
    idle_bits(12);
    build_frame(F1, 1'b1);
    uq[62] = !uq[62];
    stuff_frame();
    clear_mon();
    send_range(0, sq.size());
    vectors++; if (err_cnt != 1) begin miscompares++; $display("FAIL crc_err_cnt: got %0d want 1", err_cnt); end
    vectors++; if (err_code_seen !== 2'd3) begin miscompares++; $display("FAIL crc_code: got %0d want 3", err_code_seen); end
    vectors++; if (err_at != body_len) begin miscompares++; $display("FAIL crc_err_at: got %0d want %0d", err_at, body_len); end
    vectors++; if (valid_cnt != 0) begin miscompares++; $display("FAIL crc_valid: got %0d want 0", valid_cnt); end
    vectors++; if (low_cnt != 0) begin miscompares++; $display("FAIL crc_ack: got %0d want 0", low_cnt); end
    // Only 10 ones since the ACK-slot zero: a dominant bit must not start a frame.
    idle_bits(2);
    drive_bit(1'b0, -1);
    vectors++; if (rx_busy_o !== 1'b0) begin miscompares++; $display("FAIL crc_integrate10: got busy %b want 0", rx_busy_o); end
    idle_bits(11);
    drive_bit(1'b0, -1);
    vectors++; if (rx_busy_o !== 1'b1) begin miscompares++; $display("FAIL crc_integrate11: got busy %b want 1", rx_busy_o); end
    idle_bits(20);
  endtask

  task automatic test_stuff_error();
    int p;
    idle_bits(12);
    build_frame(F1, 1'b1);
    stuff_frame();
    p = map_q[46] + 1;
    clear_mon();
    send_range(0, p);
    for (int k = 0; k < 6; k++) drive_bit(1'b0, p + k);
    vectors++; if (err_cnt != 1) begin miscompares++; $display("FAIL stuff_err_cnt: got %0d want 1", err_cnt); end
    vectors++; if (err_code_seen !== 2'd1) begin miscompares++; $display("FAIL stuff_code: got %0d want 1", err_code_seen); end
    vectors++; if (err_at != p + 5) begin miscompares++; $display("FAIL stuff_err_at: got %0d want %0d", err_at, p + 5); end
    vectors++; if (valid_cnt != 0) begin miscompares++; $display("FAIL stuff_valid: got %0d want 0", valid_cnt); end
    idle_bits(11);
    clear_mon();
    send_range(0, sq.size());
    idle_bits(2);
    vectors++; if (valid_cnt != 1) begin miscompares++; $display("FAIL stuff_recover_valid: got %0d want 1", valid_cnt); end
    vectors++; if (obs_f !== F1) begin miscompares++; $display("FAIL stuff_recover_fields: got %h want %h", obs_f, F1); end
    vectors++; if (err_cnt != 0) begin miscompares++; $display("FAIL stuff_recover_err: got %0d want 0", err_cnt); end
  endtask

  task automatic test_form_errors();
    idle_bits(12);
    build_frame(F1, 1'b0);
    stuff_frame();
    clear_mon();
    send_range(0, sq.size());
    idle_bits(12);
    vectors++; if (err_cnt != 1) begin miscompares++; $display("FAIL ide_err_cnt: got %0d want 1", err_cnt); end
    vectors++; if (err_code_seen !== 2'd2) begin miscompares++; $display("FAIL ide_code: got %0d want 2", err_code_seen); end
    vectors++; if (err_at != map_q[13]) begin miscompares++; $display("FAIL ide_err_at: got %0d want %0d", err_at, map_q[13]); end
    vectors++; if (valid_cnt != 0) begin miscompares++; $display("FAIL ide_valid: got %0d want 0", valid_cnt); end

    build_frame(F1, 1'b1);
    stuff_frame();
    sq[body_len + 5] = 1'b0;
    clear_mon();
    send_range(0, sq.size());
    idle_bits(12);
    vectors++; if (err_cnt != 1) begin miscompares++; $display("FAIL eof_err_cnt: got %0d want 1", err_cnt); end
    vectors++; if (err_code_seen !== 2'd2) begin miscompares++; $display("FAIL eof_code: got %0d want 2", err_code_seen); end
    vectors++; if (err_at != body_len + 5) begin miscompares++; $display("FAIL eof_err_at: got %0d want %0d", err_at, body_len + 5); end
    vectors++; if (valid_cnt != 0) begin miscompares++; $display("FAIL eof_valid: got %0d want 0", valid_cnt); end
  endtask

  task automatic test_reset_abort();
    idle_bits(12);
    build_frame(F1, 1'b1);
    stuff_frame();
    clear_mon();
    send_range(0, map_q[80]);
    rst_i = 1'b0;
    for (int i = 0; i < 3; i++) drive_bit(1'b1, -1);
    vectors++; if (err_cnt != 0) begin miscompares++; $display("FAIL abort_err: got %0d want 0", err_cnt); end
    vectors++; if (valid_cnt != 0) begin miscompares++; $display("FAIL abort_valid: got %0d want 0", valid_cnt); end
    vectors++; if (rx_busy_o !== 1'b0) begin miscompares++; $display("FAIL abort_busy: got %b want 0", rx_busy_o); end
    vectors++; if (obs_f !== '0) begin miscompares++; $display("FAIL abort_fields: got %h want 0", obs_f); end
    rst_i = 1'b1;
    idle_bits(11);
    clear_mon();
    send_range(0, sq.size());
    idle_bits(2);
    vectors++; if (valid_cnt != 1) begin miscompares++; $display("FAIL abort_recover_valid: got %0d want 1", valid_cnt); end
    vectors++; if (obs_f !== F1) begin miscompares++; $display("FAIL abort_recover_fields: got %h want %h", obs_f, F1); end
  endtask

  task automatic test_back_to_back();
    bit q2[$];
    idle_bits(12);
    build_frame(F2, 1'b1);
    stuff_frame();
    q2 = sq;
    build_frame(F1, 1'b1);
    stuff_frame();
    clear_mon();
    for (int i = 0; i < q2.size(); i++) drive_bit(q2[i], i);
    send_range(0, sq.size());
    idle_bits(2);
    vectors++; if (valid_cnt != 2) begin miscompares++; $display("FAIL b2b_valid_cnt: got %0d want 2", valid_cnt); end
    vectors++; if (first_valid_f !== F2) begin miscompares++; $display("FAIL b2b_first: got %h want %h", first_valid_f, F2); end
    vectors++; if (obs_f !== F1) begin miscompares++; $display("FAIL b2b_second: got %h want %h", obs_f, F1); end
    vectors++; if (err_cnt != 0) begin miscompares++; $display("FAIL b2b_err: got %0d want 0", err_cnt); end
    vectors++; if (low_cnt != 2) begin miscompares++; $display("FAIL b2b_ack: got %0d want 2", low_cnt); end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_dense_stuffing();
    test_crc_error();
    test_stuff_error();
    test_form_errors();
    test_reset_abort();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
